// File: rtl/elevator_pkg.sv
// elevator_pkg: state encoding, default timing constants and counter sizing for elevator_scan_ctrl.
package elevator_pkg;
    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;
    localparam int DEF_TRAVEL_CYCLES = 4;
    localparam int DEF_DOOR_CYCLES = 6;
    localparam int DEF_WEIGHT_LIMIT = 150;
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = a > b ? a : b;
        return m > 1 ? $clog2(m) : 1;
    endfunction
endpackage

// File: rtl/elev_req_mask.sv
// elev_req_mask: pending request register (clear wins over set) with hit/above/below lookup at a query floor.
module elev_req_mask #(
    parameter int NUM_FLOORS = 8,
    localparam int FLOOR_W = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] set_mask,
    input  logic [NUM_FLOORS-1:0] clr_mask,
    input  logic [FLOOR_W-1:0]    floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  hit,
    output logic                  above,
    output logic                  below
);
    always_ff @(posedge clk or posedge rst)
        if (rst) pending <= '0;
        else pending <= (pending | set_mask) & ~clr_mask;
    always_comb begin
        hit = pending[floor];
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            above = above | (pending[i] & (i > int'(floor)));
            below = below | (pending[i] & (i < int'(floor)));
        end
    end
endmodule

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: SCAN-order elevator sequencer with timed travel, timed door dwell and overload hold.
// Define ELEV_FIRE_RECALL_EN to add fire_recall (drop requests, descend to floor 0, hold the door open).
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 8,
    parameter int WEIGHT_W      = 8,
    parameter int WEIGHT_LIMIT  = DEF_WEIGHT_LIMIT,
    parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES,
    localparam int FLOOR_W      = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] floor_req,
    input  logic [WEIGHT_W-1:0]   weight,
`ifdef ELEV_FIRE_RECALL_EN
    input  logic                  fire_recall,
`endif
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic                  overload,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  idle
);
    localparam int CNT_W = cnt_width(TRAVEL_CYCLES, DOOR_CYCLES);
    localparam logic [CNT_W-1:0] TRAVEL_LD = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LD = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [WEIGHT_W-1:0] W_LIMIT = WEIGHT_W'(WEIGHT_LIMIT);

    state_t state;
    logic dir_up;
    logic [CNT_W-1:0] cnt;
    logic fire;
    logic arrive;
    logic [NUM_FLOORS-1:0] set_mask;
    logic [NUM_FLOORS-1:0] clr_mask;
    logic [FLOOR_W-1:0] query;
    logic hit_raw, above_raw, below_raw;
    logic hit, above, below;

`ifdef ELEV_FIRE_RECALL_EN
    assign fire = fire_recall;
`else
    assign fire = 1'b0;
`endif

    // On the arrival cycle the mask is queried at the floor being entered, so the stop/continue
    // decision and the floor update happen on the same edge.
    assign arrive = (state == MOVE_UP || state == MOVE_DOWN) && cnt == '0;
    always_comb begin
        set_mask = fire ? '0 : floor_req;
        clr_mask = fire ? '1 : (state == DOOR_OPEN ? NUM_FLOORS'(1) << current_floor : '0);
        query = !arrive ? current_floor
              : state == MOVE_UP ? (current_floor == TOP_FLOOR ? current_floor : current_floor + FLOOR_W'(1))
              : (current_floor == '0 ? current_floor : current_floor - FLOOR_W'(1));
    end

    elev_req_mask #(.NUM_FLOORS(NUM_FLOORS)) u_mask (
        .clk      (clk),
        .rst      (rst),
        .set_mask (set_mask),
        .clr_mask (clr_mask),
        .floor    (query),
        .pending  (pending),
        .hit      (hit_raw),
        .above    (above_raw),
        .below    (below_raw)
    );

    assign hit = hit_raw & ~fire;
    assign above = above_raw & ~fire;
    assign below = below_raw & ~fire;
    assign idle = state == IDLE && pending == '0;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            current_floor <= '0;
            dir_up <= 1'b1;
            cnt <= '0;
            moving_up <= 1'b0;
            moving_down <= 1'b0;
            door_open <= 1'b0;
            overload <= 1'b0;
        end else begin
            overload <= weight > W_LIMIT;
            case (state)
                IDLE:
                    if (overload || hit || (fire && current_floor == '0)) begin
                        state <= DOOR_OPEN;
                        door_open <= 1'b1;
                        cnt <= DOOR_LD;
                    end else if (above && (dir_up || !below)) begin
                        state <= MOVE_UP;
                        moving_up <= 1'b1;
                        dir_up <= 1'b1;
                        cnt <= TRAVEL_LD;
                    end else if (fire || below) begin
                        state <= MOVE_DOWN;
                        moving_down <= 1'b1;
                        dir_up <= 1'b0;
                        cnt <= TRAVEL_LD;
                    end
                MOVE_UP, MOVE_DOWN:
                    if (!arrive) cnt <= cnt - CNT_W'(1);
                    else begin
                        current_floor <= query;
                        if (hit || (fire && query == '0)) begin
                            state <= DOOR_OPEN;
                            moving_up <= 1'b0;
                            moving_down <= 1'b0;
                            door_open <= 1'b1;
                            cnt <= DOOR_LD;
                        end else if (fire ? state == MOVE_DOWN : (state == MOVE_UP ? above : below)) begin
                            cnt <= TRAVEL_LD;
                        end else begin
                            state <= IDLE;
                            moving_up <= 1'b0;
                            moving_down <= 1'b0;
                        end
                    end
                DOOR_OPEN:
                    if (overload || set_mask[current_floor] || (fire && current_floor == '0)) cnt <= DOOR_LD;
                    else if (cnt != '0) cnt <= cnt - CNT_W'(1);
                    else begin
                        state <= IDLE;
                        door_open <= 1'b0;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb_elevator_scan_ctrl: per-cycle check against a floor/timer behavioural model plus directed scenario checks.
module tb_elevator_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fire = 1'b0;
    logic [7:0] floor_req = 8'h00;
    logic [7:0] weight = 8'h00;
    logic [2:0] current_floor;
    logic moving_up, moving_down, door_open, overload, idle;
    logic [7:0] pending;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    elevator_scan_ctrl #(
        .NUM_FLOORS(8), .WEIGHT_W(8), .WEIGHT_LIMIT(150), .TRAVEL_CYCLES(4), .DOOR_CYCLES(6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .floor_req     (floor_req),
        .weight        (weight),
`ifdef ELEV_FIRE_RECALL_EN
        .fire_recall   (fire),
`endif
        .current_floor (current_floor),
        .moving_up     (moving_up),
        .moving_down   (moving_down),
        .door_open     (door_open),
        .overload      (overload),
        .pending       (pending),
        .idle          (idle)
    );

    // act: 0 at rest, +1 travelling up, -1 travelling down, 2 door open; tmr counts remaining cycles of the phase
    typedef struct packed {
        int fl;
        int act;
        int tmr;
        int dir;
        logic [7:0] pend;
        logic ovl;
    } mdl_t;
    localparam mdl_t M_RST = '{fl: 0, act: 0, tmr: 0, dir: 1, pend: 8'h00, ovl: 1'b0};
    mdl_t m;

    function automatic int n_above(input logic [7:0] p, input int f);
        int c = 0;
        for (int i = f + 1; i < 8; i++) c += int'(p[i]);
        return c;
    endfunction

    function automatic int n_below(input logic [7:0] p, input int f);
        int c = 0;
        for (int i = 0; i < f; i++) c += int'(p[i]);
        return c;
    endfunction

    function automatic mdl_t step(input mdl_t c, input logic [7:0] req, input logic [7:0] w, input logic fr);
        mdl_t n = c;
        n.ovl = w > 8'd150;
        n.pend = fr ? 8'h00 : (c.pend | req);
        if (c.act == 2) n.pend[c.fl] = 1'b0;
        if (c.act == 0) begin
            if (c.ovl || (c.pend[c.fl] && !fr) || (fr && c.fl == 0)) begin
                n.act = 2; n.tmr = 6;
            end else if (fr) begin
                n.act = -1; n.dir = -1; n.tmr = 4;
            end else if (n_above(c.pend, c.fl) > 0 && (c.dir > 0 || n_below(c.pend, c.fl) == 0)) begin
                n.act = 1; n.dir = 1; n.tmr = 4;
            end else if (n_below(c.pend, c.fl) > 0) begin
                n.act = -1; n.dir = -1; n.tmr = 4;
            end
        end else if (c.act == 2) begin
            if (c.ovl || (req[c.fl] && !fr) || (fr && c.fl == 0)) n.tmr = 6;
            else if (c.tmr > 1) n.tmr = c.tmr - 1;
            else n.act = 0;
        end else if (c.tmr > 1) begin
            n.tmr = c.tmr - 1;
        end else begin
            int ahead;
            n.fl = c.fl + c.act;
            ahead = c.act > 0 ? n_above(c.pend, n.fl) : n_below(c.pend, n.fl);
            if ((c.pend[n.fl] && !fr) || (fr && n.fl == 0)) begin
                n.act = 2; n.tmr = 6;
            end else if (fr ? c.act < 0 : ahead > 0) n.tmr = 4;
            else n.act = 0;
        end
        return n;
    endfunction

    always_ff @(posedge clk or posedge rst)
        if (rst) m <= M_RST;
        else m <= step(m, floor_req, weight, fire);

    logic [15:0] outs, exp_outs;
    assign outs = {current_floor, moving_up, moving_down, door_open, overload, pending, idle};
    assign exp_outs = {3'(m.fl), m.act == 1, m.act == -1, m.act == 2, m.ovl, m.pend, m.act == 0 && m.pend == 8'h00};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst) chk("model {floor,up,dn,door,ovl,pending,idle}", 32'(outs), 32'(exp_outs));
    end

    int mu, dp, dc, opens, f1, f2, p3;
    logic prev, seen3;
    logic [7:0] pacc;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(outs), 32'h0001);
        rst = 1'b0;
        // 1: single request two floors up
        @(negedge clk) floor_req = 8'h04;
        mu = 0; dp = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk) floor_req = 8'h00;
            mu += int'(moving_up);
            dp += int'(door_open);
        end
        chk("t1_moving_up_cycles", 32'(mu), 32'd8);
        chk("t1_door_cycles", 32'(dp), 32'd6);
        chk("t1_floor", 32'(current_floor), 32'd2);
        chk("t1_pending", 32'(pending), 32'h00);
        chk("t1_idle", 32'(idle), 32'd1);
        // 2: SCAN order, 6 before 1
        @(negedge clk) floor_req = 8'h42;
        opens = 0; f1 = -1; f2 = -1; p3 = -1; prev = 1'b0; seen3 = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk) floor_req = 8'h00;
            if (door_open && !prev) begin
                opens++;
                if (opens == 1) f1 = int'(current_floor);
                if (opens == 2) f2 = int'(current_floor);
            end
            if (current_floor == 3'd3 && moving_up && !seen3) begin
                seen3 = 1'b1;
                p3 = int'(pending);
            end
            prev = door_open;
        end
        chk("t2_pending_at_3_up", 32'(p3), 32'h42);
        chk("t2_door_openings", 32'(opens), 32'd2);
        chk("t2_first_stop", 32'(f1), 32'd6);
        chk("t2_second_stop", 32'(f2), 32'd1);
        // 3: request to the open floor restarts the dwell
        @(negedge clk) floor_req = 8'h04;
        dc = 0; pacc = 8'h00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (door_open) begin
                dc++;
                if (dc > 1) pacc = pacc | pending;
            end
            floor_req = (door_open && dc == 4) ? 8'h04 : 8'h00;
        end
        chk("t3_door_cycles", 32'(dc), 32'd10);
        chk("t3_pending_stays_0", 32'(pacc), 32'h00);
        chk("t3_floor", 32'(current_floor), 32'd2);
        // 4: overload holds the door
        @(negedge clk) weight = 8'd151;
        repeat (20) @(negedge clk);
        chk("t4_overload", 32'(overload), 32'd1);
        chk("t4_door_held", 32'(door_open), 32'd1);
        weight = 8'd150;
        dc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            dc += int'(door_open);
        end
        chk("t4_door_after_clear", 32'(dc), 32'd6);
        chk("t4_overload_clear", 32'(overload), 32'd0);
        // 5: top floor, then async reset while moving up
        @(negedge clk) floor_req = 8'h80;
        for (int i = 0; i < 50; i++) @(negedge clk) floor_req = 8'h00;
        chk("t5_top_floor", 32'(current_floor), 32'd7);
        chk("t5_idle_at_top", 32'(idle), 32'd1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        floor_req = 8'h80;
        @(negedge clk) floor_req = 8'h00;
        repeat (9) @(negedge clk);
        chk("t5_mid_move_up", 32'(moving_up), 32'd1);
        #2 rst = 1'b1;
        #1 chk("t5_async_reset", 32'(outs), 32'h0001);
        @(negedge clk) rst = 1'b0;
`ifdef ELEV_FIRE_RECALL_EN
        // 6: fire recall from floor 5 with requests pending
        @(negedge clk) floor_req = 8'h20;
        for (int i = 0; i < 40; i++) @(negedge clk) floor_req = 8'h00;
        chk("t6_start_floor", 32'(current_floor), 32'd5);
        floor_req = 8'h81;
        @(negedge clk) floor_req = 8'h00;
        chk("t6_pending_before", 32'(pending), 32'h81);
        fire = 1'b1;
        repeat (40) @(negedge clk);
        chk("t6_floor0", 32'(current_floor), 32'd0);
        chk("t6_door_held", 32'(door_open), 32'd1);
        chk("t6_pending_0", 32'(pending), 32'h00);
        fire = 1'b0;
        repeat (12) @(negedge clk);
        chk("t6_door_closed", 32'(door_open), 32'd0);
`endif
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
